// File: rtl/risc_pkg.sv
// Shared constants for the front end: instruction width, opcode field
// encodings and the illegal-opcode test used by the fetch stage.
package risc_pkg;

    localparam int INST_W = 32;

    // Major opcode lives in inst[31:29].
    typedef enum logic [2:0] {
        OP_R    = 3'b000,
        OP_I    = 3'b001,
        OP_MEM  = 3'b010,
        OP_BR   = 3'b011,
        OP_J    = 3'b100,
        OP_JR   = 3'b101,
        OP_ILL0 = 3'b110,
        OP_ILL1 = 3'b111
    } opcode_e;

    localparam logic [INST_W-1:0] NOP_WORD = '0;

    // True when the word carries one of the two reserved opcodes.
    function automatic logic is_illegal_op(input logic [INST_W-1:0] w);
        return (w[31:29] == OP_ILL0) || (w[31:29] == OP_ILL1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the fetch buffer. Head word is visible
// combinationally on rdata. flush empties the FIFO and wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop & !empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order reads to instruction
// memory, buffers returned words and presents {inst, pc} to decode.
// Redirects restart fetch at a new PC and drop wrong-path words in flight.
// Optional build macro: ILLEGAL_OP_EN enables the sticky illegal-opcode
// flag and halts fetch after a reserved opcode is received.
//
// Handshakes: inst_valid/inst_ready -- a word transfers on a cycle where both
// are high; while inst_valid is high and inst_ready low, inst/inst_pc hold.
// imem_req has no ready: memory accepts every request, and responses come
// back in request order on imem_rvalid, at least one cycle later.
module instr_fetch
    import risc_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [AW-1:0]     redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [AW-1:0]     inst_pc,
    output logic [AW-1:0]     inst_pc_plus4,
    output logic              illegal
);

    localparam int            OW      = $clog2(DEPTH + 1);
    localparam logic [OW:0]   DEPTH_L = (OW + 1)'(DEPTH);

    logic [AW-1:0]        pc;
    logic                 fetch_en;     // low during and for one cycle after reset
    logic [OW-1:0]        outstanding;  // requests issued, response not yet seen
    logic [OW-1:0]        discard;      // in-flight responses that belong to a dead path
    logic                 halted;
    logic [AW-1:0]        tag_q [DEPTH];
    logic [OW-1:0]        tag_wp;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [OW:0]          inflight;

    logic [OW-1:0]        buf_count;
    logic                 buf_empty;
    logic [INST_W+AW-1:0] buf_wdata;
    logic [INST_W+AW-1:0] buf_rdata;

    // Issue/accept decisions for this cycle.
    always_comb begin
        pop      = inst_valid & inst_ready;
        // Words that will occupy buffer space once every request returns.
        inflight = {1'b0, outstanding} + {1'b0, buf_count} - {{OW{1'b0}}, pop};
        issue    = fetch_en & !redirect_valid & !halted & (inflight < DEPTH_L);
        // A redirect kills any word returning in the same cycle.
        push     = imem_rvalid & (discard == '0) & !redirect_valid;
        // The oldest tag leaves on a response, so the new tag lands one lower.
        tag_wp   = outstanding - OW'(imem_rvalid);
    end

    assign imem_req  = issue;
    assign imem_addr = pc;

    // Fetch enable comes up one cycle after reset so no request overlaps reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_en <= 1'b0;
        else     fetch_en <= 1'b1;
    end

    // Program counter: redirect target (word aligned) or sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc & ~AW'(3);
        else if (issue)          pc <= pc + AW'(4);
    end

    // Outstanding request count; issue is suppressed on redirect cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) outstanding <= '0;
        else     outstanding <= outstanding + OW'(issue) - OW'(imem_rvalid);
    end

    // Wrong-path drop counter: on redirect everything still in flight is dead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 discard <= '0;
        else if (redirect_valid)                 discard <= outstanding - OW'(imem_rvalid);
        else if (imem_rvalid && discard != '0)   discard <= discard - 1'b1;
    end

    // PC tags of outstanding requests, oldest at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue && tag_wp == OW'(i))
                    tag_q[i] <= pc;
                else if (imem_rvalid)
                    tag_q[i] <= tag_q[(i + 1 < DEPTH) ? i + 1 : i];
            end
        end
    end

`ifdef ILLEGAL_OP_EN
    // Reserved opcode: flag it (sticky until reset) and stop fetching until redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
            halted  <= 1'b0;
        end else if (redirect_valid) begin
            halted  <= 1'b0;
        end else if (push && is_illegal_op(imem_rdata)) begin
            illegal <= 1'b1;
            halted  <= 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
    assign halted  = 1'b0;
`endif

    assign buf_wdata = {imem_rdata, tag_q[0]};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (INST_W + AW),
        .CW    (OW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (buf_wdata),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (buf_rdata),
        .count (buf_count),
        .empty (buf_empty)
    );

    assign inst_valid    = !buf_empty;
    assign inst          = buf_rdata[AW +: INST_W];
    assign inst_pc       = buf_rdata[AW-1:0];
    assign inst_pc_plus4 = inst_pc + AW'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with variable latency,
// program-order reference of the PCs decode must see, random traffic phase.
module tb_instr_fetch;

    localparam int AW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic [AW-1:0] inst_pc_plus4;
    logic          illegal;

    always #5 clk = ~clk;

    instr_fetch #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4),
        .illegal        (illegal)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          ill_mode  = 1'b0;
    bit          ill_track = 1'b0;
    logic [31:0] ill_max   = '0;

    // Scoreboard: PCs decode must accept, in program order.
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } req_t;
    req_t mq[$];
    int   last_rdy = 0;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w     = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        w[31] = 1'b0;
        if (ill_mode && a == 32'h10) w = 32'hE000_0000;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Program order restarts at target t; queue holds plenty of future PCs.
    task automatic restart(input logic [31:0] t);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(t + 32'(i * 4));
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] t);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = t;
        @(negedge clk);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    // Memory: capture requests, answer in order after the chosen latency.
    always @(negedge clk) begin
        if (!rst && imem_req) begin
            req_t r;
            int   t;
            t = cyc + int'($urandom_range(lat_max, lat_min));
            if (t <= last_rdy) t = last_rdy + 1;
            last_rdy = t;
            r.addr = imem_addr;
            r.rdy  = t;
            mq.push_back(r);
            check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (ill_track && imem_addr > ill_max) ill_max = imem_addr;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (imem_rvalid) void'(mq.pop_front());
            if (mq.size() > 0 && mq[0].rdy <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mq[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    // Monitor: compare every accepted word against program order.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst, prev_pc;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, inst_valid}, 32'd1);
                check("stall_inst", inst, prev_inst);
                check("stall_pc", inst_pc, prev_pc);
            end
            prev_stall = inst_valid && !inst_ready && !redirect_valid;
            prev_inst  = inst;
            prev_pc    = inst_pc;
            if (redirect_valid) begin
                check("req_on_redirect", {31'b0, imem_req}, 32'd0);
                restart(redirect_pc & ~32'h3);
            end else if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("exp_empty", inst_pc, 32'hDEAD_BEEF);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst", inst, mem_word(e));
                    check("pc_plus4", inst_pc_plus4, e + 32'd4);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        restart(32'h0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        inst_ready = 1'b1;

        // Latency 1, decode always ready: one word per cycle once primed.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 3) check("stream_valid", {31'b0, inst_valid}, 32'd1);
        end

        // Decode stall: outputs hold, fetch stops once the buffer is full.
        @(posedge clk); #1;
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("stall_req_low", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        repeat (8) @(negedge clk);

        // Latency 3, redirect with requests in flight.
        lat_min = 3;
        lat_max = 3;
        repeat (12) @(negedge clk);
        do_redirect(32'h103);
        @(negedge clk);
        check("redir_gap", {31'b0, inst_valid}, 32'd0);
        wait_valid(20, "redir_timeout");
        check("redir_first", inst_pc, 32'h100);
        repeat (10) @(negedge clk);

        // Latency 1: redirect lands together with a response and a pop.
        lat_min = 1;
        lat_max = 1;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("pop_on_redirect", {31'b0, inst_valid}, 32'd1);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_gap", {31'b0, inst_valid}, 32'd0);
        wait_valid(20, "flush_timeout");
        check("flush_first", inst_pc, 32'h200);
        repeat (6) @(negedge clk);

        // Top-of-address-space wrap.
        do_redirect(32'hFFFF_FFFC);
        wait_valid(20, "wrap_timeout");
        check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", inst_pc_plus4, 32'h0);
        repeat (8) @(negedge clk);

`ifdef ILLEGAL_OP_EN
        // Reserved opcode at 0x10 halts fetch; redirect resumes.
        ill_mode  = 1'b1;
        ill_track = 1'b1;
        ill_max   = '0;
        do_redirect(32'h0);
        repeat (20) @(negedge clk);
        check("ill_flag", {31'b0, illegal}, 32'd1);
        check("ill_no_req", {31'b0, imem_req}, 32'd0);
        check("ill_max_req", {31'b0, (ill_max <= 32'h14)}, 32'd1);
        ill_track = 1'b0;
        do_redirect(32'h40);
        wait_valid(20, "ill_resume");
        check("ill_resume_pc", inst_pc, 32'h40);
        repeat (6) @(negedge clk);
        ill_mode = 1'b0;
`endif

        // Random traffic: variable latency, random stalls and redirects.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            inst_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = $urandom;
        end
        @(posedge clk); #1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        repeat (30) @(negedge clk);

`ifndef ILLEGAL_OP_EN
        check("illegal_tied", {31'b0, illegal}, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
